// File: rtl/led_blinker_defs_pkg.sv
// Shared definitions for the LED blinker and its input conditioner.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package led_blinker_defs;

    // System clock feeding the blinker and its front end.
    localparam int CLK_HZ = 25000;

    // 10 ms of stable input at CLK_HZ before a new level is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250;

    // Meaning of {switch_1, switch_2} as seen by the blinker.
    typedef enum logic [1:0] {
        RATE_100HZ = 2'b00,
        RATE_50HZ  = 2'b01,
        RATE_10HZ  = 2'b10,
        RATE_1HZ   = 2'b11
    } rate_sel_e;

    // Blink frequency in Hz selected by a rate code.
    function automatic int rate_hz(input rate_sel_e sel);
        int hz;
        case (sel)
            RATE_100HZ: hz = 100;
            RATE_50HZ:  hz = 50;
            RATE_10HZ:  hz = 10;
            RATE_1HZ:   hz = 1;
            default:    hz = 1;
        endcase
        return hz;
    endfunction

    // Clock cycles in half a blink period for a rate code.
    function automatic int half_period_cycles(input rate_sel_e sel);
        return CLK_HZ / (2 * rate_hz(sel));
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises one asynchronous bouncy input and accepts a new level only after it is stable.
// Latency: a held level appears on dout after SYNC_STAGES + DEBOUNCE_CYCLES posedges.
// Backpressure: none; the input is sampled every cycle.
//
// Ports:
//   clock    in  system clock, posedge
//   reset    in  synchronous active-high reset
//   din_raw  in  raw asynchronous input
//   dout     out debounced level (registered)
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 250,
    parameter int CNT_W           = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din_raw,
    output logic dout
);

    // Counter value on which the candidate level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sync_last;

    // Only the final synchroniser stage is trusted as metastability-free.
    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din_raw};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_last == stable_q) begin
            // Any return to the accepted level restarts the qualification window.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_last;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/led_input_conditioner.sv
// Conditions the blinker's two rate switches and enable button: sync, debounce, toggle enable.
// Latency: switches SYNC_STAGES+DEBOUNCE_CYCLES posedges; enable and select_changed one more.
// Backpressure: none; raw inputs are sampled every cycle, outputs are always valid.
//
// Ports:
//   clock           in  25 kHz system clock, posedge
//   reset           in  synchronous active-high reset
//   sw1_raw         in  raw slide switch 1 (async, bouncy)
//   sw2_raw         in  raw slide switch 2 (async, bouncy)
//   btn_en_raw      in  raw enable button, 1 = pressed (async, bouncy)
//   switch_1        out debounced sw1 level
//   switch_2        out debounced sw2 level
//   enable          out latched enable, toggled once per debounced press
//   select_changed  out one-cycle pulse after {switch_1,switch_2} changes
module led_input_conditioner
    import led_blinker_defs::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   CNT_W           = 8,
    parameter int   SYNC_STAGES     = 2,
    parameter logic EN_RESET_VALUE  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic sw1_raw,
    input  logic sw2_raw,
    input  logic btn_en_raw,
    output logic switch_1,
    output logic switch_2,
    output logic enable,
    output logic select_changed
);

    logic      sw1_stable, sw2_stable, btn_stable;
    logic      btn_dly_q, btn_dly_d;
    logic      enable_q, enable_d;
    rate_sel_e sel_prev_q, sel_prev_d;
    logic      sel_chg_q, sel_chg_d;
    rate_sel_e sel_now;
    logic      btn_rise;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_sw1_filter (
        .clock   (clock),
        .reset   (reset),
        .din_raw (sw1_raw),
        .dout    (sw1_stable)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_sw2_filter (
        .clock   (clock),
        .reset   (reset),
        .din_raw (sw2_raw),
        .dout    (sw2_stable)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_filter (
        .clock   (clock),
        .reset   (reset),
        .din_raw (btn_en_raw),
        .dout    (btn_stable)
    );

    always_comb begin
        sel_now    = rate_sel_e'({sw1_stable, sw2_stable});
        // Press edge only: a held button or its release never toggles again.
        btn_rise   = btn_stable & ~btn_dly_q;
        btn_dly_d  = btn_stable;
        enable_d   = enable_q ^ btn_rise;
        sel_prev_d = sel_now;
        // Comparing the 2-bit code as a whole makes a double flip a single pulse.
        sel_chg_d  = (sel_now != sel_prev_q);
    end

    // The history registers reset to the same values the filters reset to,
    // so neither a press nor a select change is seen on the first cycle out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_dly_q  <= 1'b0;
            enable_q   <= EN_RESET_VALUE;
            sel_prev_q <= RATE_100HZ;
            sel_chg_q  <= 1'b0;
        end else begin
            btn_dly_q  <= btn_dly_d;
            enable_q   <= enable_d;
            sel_prev_q <= sel_prev_d;
            sel_chg_q  <= sel_chg_d;
        end
    end

    assign switch_1       = sw1_stable;
    assign switch_2       = sw2_stable;
    assign enable         = enable_q;
    assign select_changed = sel_chg_q;

endmodule

// File: tb/tb_led_input_conditioner.sv
// Self-checking bench for led_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_input_conditioner;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int HL = S + D;

    logic clock = 1'b0;
    logic reset, sw1_raw, sw2_raw, btn_en_raw;
    logic switch_1, switch_2, enable, select_changed;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #20 clock = ~clock;

    led_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .SYNC_STAGES     (S),
        .EN_RESET_VALUE  (1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sw1_raw        (sw1_raw),
        .sw2_raw        (sw2_raw),
        .btn_en_raw     (btn_en_raw),
        .switch_1       (switch_1),
        .switch_2       (switch_2),
        .enable         (enable),
        .select_changed (select_changed)
    );

    // Reference model: an input's accepted level flips at an edge when the
    // D raw samples taken S..S+D-1 edges earlier all disagree with it.
    // Index 0 = sw1, 1 = sw2, 2 = button.
    bit m_hist [3][HL];   // [i][0] oldest sample, [i][HL-1] newest
    bit m_st   [3];
    bit m_en, m_sc, rise_pend, sel_pend;

    task automatic model_edge(input bit r, input bit raw0, input bit raw1, input bit raw2);
        bit raw [3];
        bit old [3];
        bit all_diff;
        raw[0] = raw0; raw[1] = raw1; raw[2] = raw2;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < HL; j++) m_hist[i][j] = 1'b0;
                m_st[i] = 1'b0;
            end
            m_en = 1'b1; m_sc = 1'b0; rise_pend = 1'b0; sel_pend = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                old[i] = m_st[i];
                for (int j = 0; j < HL - 1; j++) m_hist[i][j] = m_hist[i][j+1];
                m_hist[i][HL-1] = raw[i];
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (m_hist[i][j] == old[i]) all_diff = 1'b0;
                if (all_diff) m_st[i] = ~old[i];
            end
            // Effects of a level change land one edge after the change.
            m_en      = m_en ^ rise_pend;
            m_sc      = sel_pend;
            rise_pend = m_st[2] & ~old[2];
            sel_pend  = (m_st[0] != old[0]) || (m_st[1] != old[1]);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the posedge and compare to the model.
    task automatic step(input logic r, input logic s1, input logic s2, input logic b);
        reset = r; sw1_raw = s1; sw2_raw = s2; btn_en_raw = b;
        @(posedge clock);
        #1;
        cyc++;
        model_edge(r, s1, s2, b);
        chk("model_switch_1", switch_1, m_st[0]);
        chk("model_switch_2", switch_2, m_st[1]);
        chk("model_enable", enable, m_en);
        chk("model_select_changed", select_changed, m_sc);
    endtask

    typedef struct {
        logic rst, s1, s2, b;
        logic e_s1, e_s2, e_en, e_sc;
    } vec_t;

    vec_t vt [11];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  run [3];
        bit  cur [3];
        int  pulses;
        bit  r;

        reset = 1'b1; sw1_raw = 1'b0; sw2_raw = 1'b0; btn_en_raw = 1'b0;

        // Reset for 3 cycles, then sw1 0->1 held: rises on the 6th edge, pulse one edge later.
        //            rst  s1   s2   b    e_s1 e_s2 e_en e_sc
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[3]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[4]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[5]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[6]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
        vt[8]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0};
        vt[9]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1};
        vt[10] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0};

        for (int i = 0; i < 11; i++) begin
            step(vt[i].rst, vt[i].s1, vt[i].s2, vt[i].b);
            chk("tbl_switch_1", switch_1, vt[i].e_s1);
            chk("tbl_switch_2", switch_2, vt[i].e_s2);
            chk("tbl_enable", enable, vt[i].e_en);
            chk("tbl_select_changed", select_changed, vt[i].e_sc);
        end

        // Bounce on sw2: 3-cycle runs never qualify.
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, ((k / 3) % 2) == 0, 1'b0);
            chk("bounce_sw2_low", switch_2, 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk("bounce_sw2_rise", switch_2, k >= 6);
        end

        // Button: press toggles once, release does nothing, second press toggles back.
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            chk("btn_press1", enable, k < 7);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk("btn_release", enable, 1'b0);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            chk("btn_press2", enable, k >= 7);
        end

        // Both switches flip together: same-cycle change, single pulse.
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("simul_sw1", switch_1, k < 6);
            chk("simul_sw2", switch_2, k < 6);
            chk("simul_pulse", select_changed, k == 7);
            if (select_changed === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL simul_pulse_count: got %0d expected 1", pulses);
        end

        // Reset in the middle of a sw1 qualification discards the partial count.
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("midrst_pre", switch_1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_in_reset", switch_1, 1'b0);
        chk("midrst_enable", enable, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("midrst_rise", switch_1, k >= 6);
        end

        // Random bouncy traffic with occasional resets, checked against the model.
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            cur[i] = 1'b1;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (run[i] == 0) begin
                    cur[i] = $urandom_range(0, 1) == 1;
                    run[i] = $urandom_range(1, 10);
                end
                run[i]--;
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, cur[0], cur[1], cur[2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
